// File: rtl/flash_frame_writer.sv
// flash_frame_writer: stores one frame in SPI NOR flash by sequencing
// write-enable, optional 4 KiB sector erases, page programs and WIP status
// polls through an external SPI engine. The engine moves the page payload;
// this block only decides which command goes out next and where.
module flash_frame_writer #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          NUM_SECTORS = 75,
    parameter int          NUM_PAGES   = 1200,
    parameter int          PAGE_BYTES  = 256,
    parameter bit          ERASE_EN    = 1'b1,
    parameter int          POLL_GAP    = 100,
    parameter logic [15:0] MAX_POLLS   = 16'd60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        spi_req,
    output logic [7:0]  spi_cmd,
    output logic [3:0]  spi_type,
    output logic [23:0] spi_addr,
    input  logic        spi_ack,
    input  logic [7:0]  spi_rdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] progress
);

    typedef enum logic [2:0] {
        IDLE, WREN, ERASE, PROG, POLL, GAP, FINISH, ERR
    } state_t;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_ERASE = 8'h20;
    localparam logic [7:0] OP_PROG  = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    localparam logic [3:0] TYPE_CMD   = 4'b1001;
    localparam logic [3:0] TYPE_WRITE = 4'b1101;
    localparam logic [3:0] TYPE_READ  = 4'b1011;

    localparam int          PAGE_SHIFT   = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 0;
    localparam bit          ERASE_PHASE  = (ERASE_EN != 1'b0) && (NUM_SECTORS > 0);
    localparam logic [15:0] SECTOR_COUNT = 16'(NUM_SECTORS);
    localparam logic [15:0] PAGE_COUNT   = 16'(NUM_PAGES);
    localparam logic [15:0] GAP_LAST     = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

    state_t      state;
    state_t      state_next;

    logic        start_prev;
    logic        prev_valid;
    logic        start_edge;
    logic [15:0] sector_idx;
    logic [15:0] page_idx;
    logic [15:0] poll_cnt;
    logic [15:0] gap_cnt;
    logic        erase_done;
    logic        abort_seen;

    logic        ack_ok;
    logic        wip;
    logic        timeout;
    logic        abort_any;
    logic        erase_pending;
    logic        cmd_state;
    logic        issue;
    logic        sector_last;
    logic        page_last;
    logic [23:0] erase_addr;
    logic [23:0] prog_addr;
    logic [7:0]  cmd_sel;
    logic [3:0]  type_sel;
    logic [23:0] addr_sel;
    logic        unused_rdata;

    // prev_valid keeps a start level that was already high during reset from
    // looking like a fresh edge on the first cycle after release.
    assign start_edge    = start & ~start_prev & prev_valid;
    assign ack_ok        = spi_req & spi_ack;
    assign wip           = spi_rdata[0];
    assign unused_rdata  = ^spi_rdata[7:1];
    assign timeout       = (poll_cnt >= MAX_POLLS);
    assign abort_any     = abort | abort_seen;
    assign erase_pending = ERASE_PHASE & ~erase_done;
    assign cmd_state     = (state == WREN) || (state == ERASE) ||
                           (state == PROG) || (state == POLL);
    assign issue         = cmd_state & ~spi_req;
    assign sector_last   = ((sector_idx + 16'd1) == SECTOR_COUNT);
    assign page_last     = ((page_idx + 16'd1) == PAGE_COUNT);
    assign erase_addr    = BASE_ADDR + {sector_idx[11:0], 12'h000};
    assign prog_addr     = BASE_ADDR + (24'(page_idx) << PAGE_SHIFT);
    assign busy          = (state != IDLE);
    assign done          = (state == FINISH);

    // State register; reset wins over everything, even an open transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision plus the command fields for the state being issued.
    always_comb begin
        state_next = state;
        cmd_sel    = 8'h00;
        type_sel   = 4'h0;
        addr_sel   = 24'h000000;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next = (NUM_PAGES == 0) ? FINISH : WREN;
                end
            end
            WREN: begin
                cmd_sel  = OP_WREN;
                type_sel = TYPE_CMD;
                if (ack_ok) begin
                    if (abort_any) begin
                        state_next = IDLE;
                    end else if (erase_pending) begin
                        state_next = ERASE;
                    end else begin
                        state_next = PROG;
                    end
                end
            end
            ERASE: begin
                cmd_sel  = OP_ERASE;
                type_sel = TYPE_CMD;
                addr_sel = erase_addr;
                if (ack_ok) begin
                    state_next = abort_any ? IDLE : POLL;
                end
            end
            PROG: begin
                cmd_sel  = OP_PROG;
                type_sel = TYPE_WRITE;
                addr_sel = prog_addr;
                if (ack_ok) begin
                    state_next = abort_any ? IDLE : POLL;
                end
            end
            POLL: begin
                cmd_sel  = OP_RDSR;
                type_sel = TYPE_READ;
                if (ack_ok) begin
                    if (wip) begin
                        if (timeout) begin
                            state_next = ERR;
                        end else if (abort_any) begin
                            state_next = IDLE;
                        end else if (POLL_GAP == 0) begin
                            state_next = POLL;
                        end else begin
                            state_next = GAP;
                        end
                    end else if (abort_any) begin
                        state_next = IDLE;
                    end else if (erase_pending) begin
                        state_next = WREN;
                    end else if (page_last) begin
                        state_next = FINISH;
                    end else begin
                        state_next = WREN;
                    end
                end
            end
            GAP: begin
                if (abort_any) begin
                    state_next = IDLE;
                end else if (gap_cnt == GAP_LAST) begin
                    state_next = POLL;
                end
            end
            FINISH:  state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake, counters, indices and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev <= 1'b0;
            prev_valid <= 1'b0;
            spi_req    <= 1'b0;
            spi_cmd    <= 8'h00;
            spi_type   <= 4'h0;
            spi_addr   <= 24'h000000;
            sector_idx <= 16'd0;
            page_idx   <= 16'd0;
            progress   <= 16'd0;
            poll_cnt   <= 16'd0;
            gap_cnt    <= 16'd0;
            erase_done <= 1'b0;
            abort_seen <= 1'b0;
            error      <= 1'b0;
        end else begin
            start_prev <= start;
            prev_valid <= 1'b1;

            if (ack_ok) begin
                spi_req <= 1'b0;
            end else if (issue) begin
                spi_req  <= 1'b1;
                spi_cmd  <= cmd_sel;
                spi_type <= type_sel;
                spi_addr <= addr_sel;
            end

            if ((state_next != POLL) && (state_next != GAP)) begin
                poll_cnt <= 16'd0;
            end else if (issue && (state == POLL)) begin
                poll_cnt <= poll_cnt + 16'd1;
            end

            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;

            if (state_next == IDLE) begin
                abort_seen <= 1'b0;
            end else if (cmd_state && abort) begin
                abort_seen <= 1'b1;
            end

            if ((state == IDLE) && start_edge) begin
                sector_idx <= 16'd0;
                page_idx   <= 16'd0;
                progress   <= 16'd0;
                erase_done <= 1'b0;
                error      <= 1'b0;
            end

            if ((state == POLL) && ack_ok && !wip && !abort_any) begin
                if (erase_pending) begin
                    sector_idx <= sector_idx + 16'd1;
                    if (sector_last) begin
                        erase_done <= 1'b1;
                    end
                end else begin
                    page_idx <= page_idx + 16'd1;
                    progress <= progress + 16'd1;
                end
            end

            if (state == ERR) begin
                error <= 1'b1;
            end
        end
    end

endmodule
